uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_baud.sv | 33 +++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/oversample constants,
// common to the TX and RX blocks.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_e;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 7;
   localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_baud.sv
// 16x-oversample tick generator: counts 0..BAUD_DIV-1 and pulses tick at the top.
// clr restarts the count so sampling phase aligns to the detected start edge.
module uart_rx_baud #(
   parameter int unsigned BAUD_DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntW'(BAUD_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling FSM, shift register
// and one-cycle we / frame_err / overrun strobes toward a downstream FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       full,
   output logic [7:0] data_o,
   output logic       we,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   uart_state_e state_q, state_d;
   logic       rx_s1_q, rx_s2_q, rx_prev_q;
   logic [3:0] os_q, os_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       good_q, good_d;
   logic       ferr_q, ferr_d;
   logic       tick;
   logic       clr;

   uart_rx_baud #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .tick(tick)
   );

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      good_d  = 1'b0;
      ferr_d  = 1'b0;
      clr     = 1'b0;
      // A good byte is resolved against full in the strobe cycle itself, so we
      // can never coincide with full and the byte is never silently dropped.
      data_d  = data_q;
      if (good_q && !full) begin
         data_d = shift_q;
      end
      case (state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s2_q) begin
               state_d = StStart;
               os_d    = '0;
               clr     = 1'b1;
            end
         end
         StStart: begin
            if (tick) begin
               if (os_q == 4'(MID_SAMPLE)) begin
                  if (!rx_s2_q) begin
                     state_d = StData;
                     os_d    = '0;
                     idx_d   = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  os_d = os_q + 4'd1;
               end
            end
         end
         StData: begin
            if (tick) begin
               os_d = os_q + 4'd1;
               if (os_q == 4'(OVERSAMPLE - 1)) begin
                  shift_d[idx_q] = rx_s2_q;
                  if (idx_q == 3'(DATA_BITS - 1)) begin
                     state_d = StStop;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
         end
         StStop: begin
            if (tick) begin
               os_d = os_q + 4'd1;
               if (os_q == 4'(OVERSAMPLE - 1)) begin
                  state_d = StIdle;
                  good_d  = rx_s2_q;
                  ferr_d  = !rx_s2_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         os_q      <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         good_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         os_q      <= os_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         good_q    <= good_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_o    = data_d;
   assign we        = good_q && !full;
   assign overrun   = good_q && full;
   assign frame_err = ferr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver predicts each frame's outcome from
// the 8N1 rules and queues it; a monitor checks every strobe the DUT produces.
module tb_uart_rx;

   localparam int unsigned BaudDiv = 4;
   localparam int          BitClks = 16 * BaudDiv;
   localparam int          LatMin  = 605;
   localparam int          LatMax  = 617;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       full = 1'b0;
   logic [7:0] data_o;
   logic       we, frame_err, overrun, busy;

   always #5 clk = ~clk;

   uart_rx #(
      .BAUD_DIV(BaudDiv)
   ) dut (
      .clk      (clk),
      .rst      (rst_n),
      .rx       (rx),
      .full     (full),
      .data_o   (data_o),
      .we       (we),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   typedef enum int {EvWe = 0, EvFerr = 1, EvOvr = 2} ev_e;
   typedef struct {
      ev_e        kind;
      logic [7:0] data;
      int         start;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         n_pulses = 0;
   int         n_expected = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: outcome of a frame follows directly from stop level and full.
   task automatic predict(input logic [7:0] b, input bit stop, input bit f);
      exp_t e;
      e.start = cyc;
      if (!stop) begin
         e.kind = EvFerr;
         e.data = last_good;
      end else if (f) begin
         e.kind = EvOvr;
         e.data = last_good;
      end else begin
         e.kind = EvWe;
         e.data = b;
         last_good = b;
      end
      sb.push_back(e);
      n_expected++;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop, input bit f);
      full = f;
      predict(b, stop, f);
      rx = 1'b0;
      wait_clks(BitClks);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(BitClks);
      end
      rx = stop;
      wait_clks(BitClks);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      wait_clks(n);
   endtask

   initial begin : monitor
      exp_t e;
      int   kind;
      forever begin
         @(negedge clk);
         if (rst_n && (we || frame_err || overrun)) begin
            n_pulses++;
            kind = we ? int'(EvWe) : (frame_err ? int'(EvFerr) : int'(EvOvr));
            check_eq("single_strobe", int'(we) + int'(frame_err) + int'(overrun), 1);
            if (we) check_eq("we_while_full", int'(full), 0);
            if (sb.size() == 0) begin
               check_eq("unexpected_strobe_kind", kind, -1);
            end else begin
               e = sb.pop_front();
               check_eq("strobe_kind", kind, int'(e.kind));
               check_eq("data_o", int'(data_o), int'(e.data));
               check_rng("strobe_latency", cyc - e.start, LatMin, LatMax);
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [7:0] b;
      bit         stop, f, prev_bad;
      int         gap;

      wait_clks(5);
      check_eq("reset_data_o", int'(data_o), 0);
      check_eq("reset_we", int'(we), 0);
      check_eq("reset_frame_err", int'(frame_err), 0);
      check_eq("reset_overrun", int'(overrun), 0);
      check_eq("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      idle(20);

      // Good byte, then a framing error followed by a held-low break.
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(20);
      send_frame(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      wait_clks(200);
      idle(300);
      check_eq("break_idle_busy", int'(busy), 0);
      check_eq("break_pulse_count", n_pulses, n_expected);

      // Short low glitch must be rejected at mid-start.
      rx = 1'b0;
      wait_clks(12);
      check_eq("glitch_busy_rise", int'(busy), 1);
      rx = 1'b1;
      wait_clks(40);
      check_eq("glitch_busy_fall", int'(busy), 0);
      idle(20);
      check_eq("glitch_pulse_count", n_pulses, n_expected);

      // Overrun with full held, then the same byte accepted.
      send_frame(8'h81, 1'b1, 1'b1);
      idle(20);
      send_frame(8'h81, 1'b1, 1'b0);
      idle(20);

      // Reset in the middle of data bit 4 of 0xFF; the partial frame is dropped.
      rx = 1'b0;
      wait_clks(BitClks);
      rx = 1'b1;
      wait_clks(4 * BitClks + BitClks / 2);
      check_eq("midframe_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_data_o", int'(data_o), 0);
      check_eq("async_reset_busy", int'(busy), 0);
      check_eq("async_reset_strobes", int'(we) + int'(frame_err) + int'(overrun), 0);
      last_good = 8'h00;
      wait_clks(10);
      rst_n = 1'b1;
      wait_clks(4 * BitClks);
      check_eq("post_reset_idle", int'(busy), 0);
      send_frame(8'h00, 1'b1, 1'b0);
      idle(20);

      // Back-to-back frames with no idle gap.
      send_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'hAA, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);

      // Randomized frames: random byte, occasional bad stop or full, random gaps.
      prev_bad = 1'b0;
      for (int n = 0; n < 14; n++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         f    = ($urandom_range(0, 3) == 0);
         gap  = $urandom_range(0, 80);
         if (prev_bad) gap += BitClks;
         if (gap > 0) idle(gap);
         send_frame(b, stop, f);
         prev_bad = !stop;
      end
      idle(BitClks);
      full = 1'b0;
      idle(200);

      check_eq("scoreboard_empty", sb.size(), 0);
      check_eq("total_strobes", n_pulses, n_expected);
      check_eq("final_idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
